// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache ports and the shared-memory port around mem_port_arbiter.
// Request/stall semantics: a port holds READ/WRITE (plus address/data) high while
// BUSYWAIT is high; BUSYWAIT low for one cycle means the block is done.
interface mem_port_arbiter_if;
  logic        D_READ;
  logic        D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;

  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;

  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  // Arbiter view.
  modport slave (
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output D_READDATA, D_BUSYWAIT,
    input  I_READ, I_ADDRESS,
    output I_READDATA, I_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  // Environment view: caches plus shared memory.
  modport master (
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  D_READDATA, D_BUSYWAIT,
    output I_READ, I_ADDRESS,
    input  I_READDATA, I_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (D-cache / I-cache) arbiter in front of one shared block memory.
// D wins ties, but at most MAX_CONSEC times in a row while I is waiting.
module mem_port_arbiter #(
  parameter  int MAX_CONSEC = 2,
  localparam int CW         = $clog2(MAX_CONSEC + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mem_port_arbiter_if.slave    bus,
  output logic [2:0]           dbg_state_o,
  output logic [CW-1:0]        dbg_dcount_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CONSEC);

  state_t        state_q;
  logic [CW-1:0] dcount_q;
  logic          started_q;
  logic          d_wr_q;
  logic [31:0]   d_rdata_q;
  logic [31:0]   i_rdata_q;
  logic [5:0]    mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic        d_req;
  logic        i_req;
  logic        busy_d;
  logic        busy_i;
  logic        d_wins;
  logic [5:0]  addr_live;

  always_comb begin
    d_req     = bus.D_READ | bus.D_WRITE;
    i_req     = bus.I_READ;
    busy_d    = (state_q == BUSY_D);
    busy_i    = (state_q == BUSY_I);
    d_wins    = d_req && (!i_req || (dcount_q < MAX_C));
    addr_live = busy_d ? bus.D_ADDRESS : bus.I_ADDRESS;
  end

  // The operation type is latched at grant so a dropped request cannot abort it.
  assign bus.MEM_READ      = (busy_d & ~d_wr_q) | busy_i;
  assign bus.MEM_WRITE     = busy_d & d_wr_q;
  assign bus.MEM_ADDRESS   = (busy_d | busy_i) ? addr_live : mem_addr_q;
  assign bus.MEM_WRITEDATA = busy_d ? bus.D_WRITEDATA : mem_wdata_q;

  assign bus.D_BUSYWAIT = d_req & (state_q != DONE_D);
  assign bus.I_BUSYWAIT = i_req & (state_q != DONE_I);
  assign bus.D_READDATA = d_rdata_q;
  assign bus.I_READDATA = i_rdata_q;

  assign dbg_state_o  = state_q;
  assign dbg_dcount_o = dcount_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      dcount_q    <= '0;
      started_q   <= 1'b0;
      d_wr_q      <= 1'b0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (busy_d || busy_i) mem_addr_q <= addr_live;
      if (busy_d) mem_wdata_q <= bus.D_WRITEDATA;

      case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q  <= BUSY_D;
            d_wr_q   <= bus.D_WRITE;
            dcount_q <= i_req ? (dcount_q + CW'(1)) : '0;
          end else if (i_req) begin
            state_q  <= BUSY_I;
            dcount_q <= '0;
          end else begin
            dcount_q <= '0;
          end
        end
        BUSY_D, BUSY_I: begin
          // Completion needs to have seen the memory go busy first.
          if (bus.MEM_BUSYWAIT) begin
            started_q <= 1'b1;
          end else if (started_q) begin
            started_q <= 1'b0;
            if (busy_d) begin
              if (!d_wr_q) d_rdata_q <= bus.MEM_READDATA;
              state_q <= DONE_D;
            end else begin
              i_rdata_q <= bus.MEM_READDATA;
              state_q   <= DONE_I;
            end
          end
        end
        DONE_D, DONE_I: state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_CONSEC, default 2, meaning the maximum number of back-to-back D-port grants while the I-port is waiting.
REQ-002 The block SHALL have port CLK, input, 1, system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports D_READ and D_WRITE, input, 1 each, data-cache block read and write requests.
REQ-005 The block SHALL have port D_ADDRESS, input, 6, data-cache block address.
REQ-006 The block SHALL have port D_WRITEDATA, input, 32, data-cache write block.
REQ-007 The block SHALL have port D_READDATA, output, 32, returned block for the D-port.
REQ-008 The block SHALL have port D_BUSYWAIT, output, 1, D-port stall.
REQ-009 The block SHALL have ports I_READ (input, 1), I_ADDRESS (input, 6), I_READDATA (output, 32) and I_BUSYWAIT (output, 1): a read-only instruction-cache port with the same meanings as the D-port.
REQ-010 The block SHALL have ports MEM_READ and MEM_WRITE (output, 1 each), MEM_ADDRESS (output, 6) and MEM_WRITEDATA (output, 32): the request to the shared data memory.
REQ-011 The block SHALL have ports MEM_READDATA (input, 32) and MEM_BUSYWAIT (input, 1): the response from the shared data memory.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY_D, BUSY_I, DONE_D and DONE_I, held in a state register.
REQ-013 Arbitration SHALL occur in IDLE at each rising edge, using the request levels sampled at that edge.
- Only D pending (D_READ|D_WRITE) -> BUSY_D.
- Only I pending (I_READ) -> BUSY_I.
- Neither pending -> stay in IDLE.
REQ-014 When both ports are pending in IDLE, the block SHALL go to BUSY_D if dcount < MAX_CONSEC, else to BUSY_I.
REQ-015 dcount SHALL be a counter of width clog2(MAX_CONSEC+1).
- Increment (saturating) on a D grant while I_READ=1.
- Clear on an I grant.
- Clear on any IDLE edge with I_READ=0.
REQ-016 In BUSY_D and BUSY_I, the MEM_* outputs SHALL combinationally mirror the owner's request, address and write data; in IDLE and DONE_* states MEM_READ=MEM_WRITE=0 and MEM_ADDRESS/MEM_WRITEDATA hold their last value.
REQ-017 On the D-port, D_WRITE=1 SHALL take precedence over D_READ: MEM_WRITE=1 and MEM_READ=0.
REQ-018 A 'started' flag SHALL be set at an edge in BUSY_x where MEM_BUSYWAIT=1, and cleared on entry to DONE_x.
REQ-019 Completion SHALL occur at an edge in BUSY_x where started=1 and MEM_BUSYWAIT=0.
- Capture MEM_READDATA into x_READDATA (reads only; writes leave x_READDATA unchanged).
- Go to DONE_x.
REQ-020 DONE_x SHALL last exactly one cycle, then go to IDLE; a new grant is possible at the following edge (minimum 1 idle edge between transactions).
REQ-021 D_BUSYWAIT SHALL equal (D_READ|D_WRITE) AND (state != DONE_D), combinationally; I_BUSYWAIT SHALL equal I_READ AND (state != DONE_I).
REQ-022 A requester dropping its request mid-transaction SHALL NOT abort the memory access; the access SHALL run to completion with read data still captured and BUSYWAIT low.
REQ-023 A request raised while the other port owns memory SHALL see BUSYWAIT=1 until its own DONE state.
REQ-024 x_READDATA SHALL hold its value between captures.

Reset
REQ-025 RESET=0 SHALL immediately, without waiting for a clock edge, set state=IDLE, dcount=0, started=0, D_READDATA=I_READDATA=0, MEM_ADDRESS=0 and MEM_WRITEDATA=0.
REQ-026 During reset, MEM_READ=MEM_WRITE=0 and x_BUSYWAIT SHALL follow REQ-021, i.e. BUSYWAIT equals the request.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no DONE pulse and no data capture; the shared memory is reset concurrently.
REQ-028 The first arbitration SHALL occur at the first rising edge after RESET returns to 1.

Verification
REQ-029 Scenario: D_READ with D_ADDRESS=6'h05 against a memory holding 32'hDEADBEEF, 5-cycle busy -> MEM_READ=1 and MEM_ADDRESS=05 during BUSY_D; D_READDATA=DEADBEEF; D_BUSYWAIT low for exactly one cycle; back to IDLE.
REQ-030 Scenario: I_READ with I_ADDRESS=6'h10 and D_WRITE with D_ADDRESS=6'h11, D_WRITEDATA=32'h12345678, raised at the same edge -> D is served first with MEM_WRITE=1; I_BUSYWAIT stays 1 throughout; I is served next; I_READDATA equals memory[10].
REQ-031 Scenario: D requests held continuously with I_READ=1 and MAX_CONSEC=2 -> grant order D, D, I, D, D, I; no third consecutive D grant.
REQ-032 Scenario: RESET driven to 0 two cycles into BUSY_I -> asynchronously state=IDLE, MEM_READ=0, I_READDATA=0; no DONE_I pulse; after release, a re-raised I_READ completes normally.
REQ-033 Scenario: D_READ=D_WRITE=1 with address 6'h3F -> only MEM_WRITE is asserted; D_READDATA is unchanged.
REQ-034 Scenario: D_READ dropped after one BUSY_D cycle -> MEM_READ stays asserted until completion, DONE_D occurs, and D_READDATA is updated.
